// File: rtl/cascade_event_arbiter_if.sv
// cascade_event_arbiter_if: requester, event-stream and flush-control signals of the cascade event arbiter
interface cascade_event_arbiter_if #(
  parameter int NUM_SRC = 4,
  parameter int DEPTH = 8
);
  localparam int SRC_W = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  logic [NUM_SRC-1:0] req_valid;
  logic [NUM_SRC-1:0] req_ready;
  logic [3*NUM_SRC-1:0] req_code;
  logic evt_valid;
  logic evt_ready;
  logic [2:0] evt_code;
  logic [SRC_W-1:0] evt_src;
  logic flush_req;
  logic det_flush;
  logic [CW-1:0] fifo_count;
  logic [7:0] drop_cnt;
  modport master (
    output req_valid, req_code, evt_ready, flush_req,
    input req_ready, evt_valid, evt_code, evt_src, det_flush, fifo_count, drop_cnt
  );
  modport slave (
    input req_valid, req_code, evt_ready, flush_req,
    output req_ready, evt_valid, evt_code, evt_src, det_flush, fifo_count, drop_cnt
  );
endinterface

// File: rtl/cascade_event_arbiter.sv
// cascade_event_arbiter: round-robin event merger with FIFO and drain/flush sequencer; FLASH_PRIORITY_EN gives code-3 requesters priority
module cascade_event_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DEPTH = 8,
  parameter int DRAIN_MAX = 64
) (
  input logic clk,
  input logic rst,
  cascade_event_arbiter_if.slave bus
);
  localparam int SRC_W = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(DRAIN_MAX + 1);
  typedef enum logic [1:0] {RUN, DRAIN, FLUSH} state_t;
  state_t state;
  logic [SRC_W-1:0] rr_ptr, rr_idx, gnt_idx;
  logic gnt_any, gnt_pri;
  logic [2:0] gnt_code;
  logic [2:0] code_mem [DEPTH];
  logic [SRC_W-1:0] src_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [DW-1:0] drain_cnt;
  logic [7:0] drop_cnt;
  logic det_flush;
  logic acc, pop, push, drop, force_clr;
  always_comb begin
    gnt_any = 1'b0;
    gnt_pri = 1'b0;
    gnt_idx = '0;
    rr_idx = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      rr_idx = SRC_W'((int'(rr_ptr) + k) % NUM_SRC);
      if (bus.req_valid[rr_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = rr_idx;
      end
    end
`ifdef FLASH_PRIORITY_EN
    for (int k = NUM_SRC - 1; k >= 0; k--)
      if (bus.req_valid[k] && bus.req_code[3*k +: 3] == 3'd3) begin
        gnt_any = 1'b1;
        gnt_pri = 1'b1;
        gnt_idx = SRC_W'(k);
      end
`endif
    gnt_code = bus.req_code[3*gnt_idx +: 3];
  end
  assign acc = gnt_any && state == RUN;
  assign pop = bus.evt_valid && bus.evt_ready;
  assign push = acc && gnt_code != 3'd0 && (count != CW'(DEPTH) || pop);
  assign drop = acc && gnt_code != 3'd0 && count == CW'(DEPTH) && !pop;
  assign force_clr = state == DRAIN && count != '0 && drain_cnt == DW'(DRAIN_MAX - 1);
  assign bus.req_ready = acc ? NUM_SRC'(1) << gnt_idx : '0;
  assign bus.evt_valid = count != '0;
  assign bus.evt_code = bus.evt_valid ? code_mem[rd_ptr] : '0;
  assign bus.evt_src = bus.evt_valid ? src_mem[rd_ptr] : '0;
  assign bus.fifo_count = count;
  assign bus.drop_cnt = drop_cnt;
  assign bus.det_flush = det_flush;
  always_ff @(posedge clk)
    if (push) begin
      code_mem[wr_ptr] <= gnt_code;
      src_mem[wr_ptr] <= gnt_idx;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= RUN;
      rr_ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      drain_cnt <= '0;
      drop_cnt <= '0;
      det_flush <= 1'b0;
    end else begin
      det_flush <= 1'b0;
      if (acc && !gnt_pri) rr_ptr <= gnt_idx == SRC_W'(NUM_SRC - 1) ? '0 : gnt_idx + 1'b1;
      if (drop && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
      if (force_clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop) count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end
      if (state == RUN && bus.flush_req) begin
        state <= DRAIN;
        drain_cnt <= '0;
      end else if (state == DRAIN) begin
        drain_cnt <= drain_cnt + 1'b1;
        if (count == '0 || force_clr) begin
          state <= FLUSH;
          det_flush <= 1'b1;
        end
      end else if (state == FLUSH) state <= RUN;
    end
endmodule

// File: tb/tb_cascade_event_arbiter.sv
// tb_cascade_event_arbiter: scoreboard bench for the cascade event arbiter
module tb_cascade_event_arbiter;
  localparam int N = 4;
  localparam int D = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_run = 0;
  int n_fail = 0;
  int exp_drop = 0;
  bit clr_ok = 1'b0;
  bit pop_m;
  logic [4:0] q[$];
  cascade_event_arbiter_if #(.NUM_SRC(N), .DEPTH(D)) bus();
  cascade_event_arbiter #(.NUM_SRC(N), .DEPTH(D), .DRAIN_MAX(64)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      exp_drop = 0;
    end else begin
      if (clr_ok && bus.det_flush) q.delete();
      n_run++;
      if (int'(bus.fifo_count) != q.size()) begin
        n_fail++;
        $display("FAIL sb_count got %0d want %0d", bus.fifo_count, q.size());
      end
      n_run++;
      if (bus.drop_cnt !== 8'(exp_drop)) begin
        n_fail++;
        $display("FAIL sb_drop got %0d want %0d", bus.drop_cnt, exp_drop);
      end
      pop_m = bus.evt_valid && bus.evt_ready;
      if (pop_m) begin
        n_run++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_event got src%0d code%0d want nothing", bus.evt_src, bus.evt_code);
        end else begin
          if ({bus.evt_src, bus.evt_code} !== q[0]) begin
            n_fail++;
            $display("FAIL sb_event got src%0d code%0d want src%0d code%0d", bus.evt_src, bus.evt_code, q[0][4:3], q[0][2:0]);
          end
          void'(q.pop_front());
        end
      end
      for (int i = 0; i < N; i++)
        if (bus.req_valid[i] && bus.req_ready[i] && bus.req_code[3*i +: 3] != 3'd0) begin
          if (q.size() < D) q.push_back({2'(i), bus.req_code[3*i +: 3]});
          else if (exp_drop < 255) exp_drop++;
        end
    end
  end

  task automatic drive(input logic [3:0] v, input logic [11:0] c, input logic er, input logic fr);
    bus.req_valid = v;
    bus.req_code = c;
    bus.evt_ready = er;
    bus.flush_req = fr;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    clr_ok = 1'b0;
    drive(4'b0, 12'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset;
    drive(4'b0, 12'b0, 1'b0, 1'b0);
    @(negedge clk); #1;
    n_run++;
    if ({bus.evt_valid, bus.fifo_count, bus.drop_cnt, bus.det_flush, bus.req_ready, bus.evt_code, bus.evt_src} !== 23'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h want 0", {bus.evt_valid, bus.fifo_count, bus.drop_cnt, bus.det_flush, bus.req_ready, bus.evt_code, bus.evt_src});
    end
    @(posedge clk); #1 rst = 1'b0;
    drive(4'b1000, {3'd5, 9'd0}, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 drive(4'b0, 12'b0, 1'b0, 1'b0);
    @(negedge clk); #1;
    n_run++;
    if (bus.fifo_count !== 4'd3) begin
      n_fail++;
      $display("FAIL prefill_count got %0d want 3", bus.fifo_count);
    end
    #1 rst = 1'b1;
    #1;
    n_run++;
    if (bus.fifo_count !== 4'd0 || bus.evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset got count %0d valid %b want 0 0", bus.fifo_count, bus.evt_valid);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_single;
    do_reset;
    drive(4'b0001, 12'd2, 1'b0, 1'b0);
    @(negedge clk); #1;
    n_run++;
    if (bus.req_ready !== 4'b0001 || bus.evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_grant got ready %b valid %b want 0001 0", bus.req_ready, bus.evt_valid);
    end
    @(posedge clk); #1 drive(4'b0, 12'b0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      n_run++;
      if (bus.evt_valid !== 1'b1 || bus.evt_code !== 3'd2 || bus.evt_src !== 2'd0) begin
        n_fail++;
        $display("FAIL single_head%0d got v%b code%0d src%0d want v1 code2 src0", k, bus.evt_valid, bus.evt_code, bus.evt_src);
      end
      @(posedge clk); #1;
    end
    drive(4'b0, 12'b0, 1'b1, 1'b0);
    @(posedge clk); #1 drive(4'b0, 12'b0, 1'b0, 1'b0);
    @(negedge clk); #1;
    n_run++;
    if (bus.evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_empty got valid %b want 0", bus.evt_valid);
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp;
    do_reset;
    drive(4'b1111, {3'd3, 3'd5, 3'd2, 3'd1}, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
`ifdef FLASH_PRIORITY_EN
      exp = 4'b1000;
`else
      exp = 4'b0001 << (k % 4);
`endif
      n_run++;
      if (bus.req_ready !== exp) begin
        n_fail++;
        $display("FAIL rr_grant%0d got %b want %b", k, bus.req_ready, exp);
      end
      @(posedge clk); #1;
    end
    drive(4'b0, 12'b0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1 drive(4'b0, 12'b0, 1'b0, 1'b0);
    @(negedge clk); #1;
    n_run++;
    if (bus.drop_cnt !== 8'd0 || bus.fifo_count !== 4'd0) begin
      n_fail++;
      $display("FAIL rr_end got drop %0d count %0d want 0 0", bus.drop_cnt, bus.fifo_count);
    end
  endtask

  task automatic test_overflow;
    do_reset;
    drive(4'b0010, {6'd0, 3'd5, 3'd0}, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk); #1;
      n_run++;
      if (bus.req_ready !== 4'b0010) begin
        n_fail++;
        $display("FAIL ovf_grant%0d got %b want 0010", k, bus.req_ready);
      end
      @(posedge clk); #1;
    end
    drive(4'b0010, {6'd0, 3'd5, 3'd0}, 1'b1, 1'b0);
    @(negedge clk); #1;
    n_run++;
    if (bus.fifo_count !== 4'd8 || bus.drop_cnt !== 8'd4) begin
      n_fail++;
      $display("FAIL ovf_full got count %0d drop %0d want 8 4", bus.fifo_count, bus.drop_cnt);
    end
    @(posedge clk); #1 drive(4'b0, 12'b0, 1'b0, 1'b0);
    @(negedge clk); #1;
    n_run++;
    if (bus.fifo_count !== 4'd8 || bus.drop_cnt !== 8'd4) begin
      n_fail++;
      $display("FAIL ovf_pushpop got count %0d drop %0d want 8 4", bus.fifo_count, bus.drop_cnt);
    end
    @(posedge clk); #1 drive(4'b0010, {6'd0, 3'd5, 3'd0}, 1'b0, 1'b0);
    repeat (260) @(posedge clk);
    #1 drive(4'b0, 12'b0, 1'b0, 1'b0);
    @(negedge clk); #1;
    n_run++;
    if (bus.drop_cnt !== 8'd255 || bus.fifo_count !== 4'd8) begin
      n_fail++;
      $display("FAIL ovf_saturate got drop %0d count %0d want 255 8", bus.drop_cnt, bus.fifo_count);
    end
    @(posedge clk); #1 drive(4'b0, 12'b0, 1'b1, 1'b0);
    repeat (8) @(posedge clk);
    #1 drive(4'b0, 12'b0, 1'b0, 1'b0);
    @(negedge clk); #1;
    n_run++;
    if (bus.fifo_count !== 4'd0) begin
      n_fail++;
      $display("FAIL ovf_drain got count %0d want 0", bus.fifo_count);
    end
  endtask

  task automatic test_drain_flush;
    logic [3:0] exp_rr;
    logic [3:0] exp_cnt;
    do_reset;
    for (int k = 0; k < 3; k++) begin
      drive(4'b0001, k == 0 ? 12'd1 : k == 1 ? 12'd2 : 12'd5, 1'b0, 1'b0);
      @(posedge clk); #1;
    end
    drive(4'b0, 12'b0, 1'b0, 1'b1);
    @(negedge clk); #1;
    n_run++;
    if (bus.fifo_count !== 4'd3 || bus.det_flush !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_start got count %0d flush %b want 3 0", bus.fifo_count, bus.det_flush);
    end
    @(posedge clk); #1 drive(4'b0001, 12'd2, 1'b1, 1'b0);
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk); #1;
      exp_rr = j == 6 ? 4'b0001 : 4'b0000;
      exp_cnt = j <= 4 ? 4'(4 - j) : 4'd0;
      n_run++;
      if (bus.req_ready !== exp_rr || bus.det_flush !== (j == 5) || bus.fifo_count !== exp_cnt) begin
        n_fail++;
        $display("FAIL drain_cycle%0d got ready %b flush %b count %0d want %b %b %0d", j, bus.req_ready, bus.det_flush, bus.fifo_count, exp_rr, j == 5, exp_cnt);
      end
      @(posedge clk); #1;
    end
    drive(4'b0, 12'b0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1 drive(4'b0, 12'b0, 1'b0, 1'b0);
  endtask

  task automatic test_drain_timeout;
    logic [3:0] exp_rr;
    logic [3:0] exp_cnt;
    do_reset;
    drive(4'b0100, {3'd0, 3'd1, 6'd0}, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1 drive(4'b0, 12'b0, 1'b0, 1'b1);
    clr_ok = 1'b1;
    @(posedge clk); #1 drive(4'b0100, {3'd0, 3'd1, 6'd0}, 1'b0, 1'b0);
    for (int j = 1; j <= 66; j++) begin
      @(negedge clk); #1;
      exp_rr = j == 66 ? 4'b0100 : 4'b0000;
      exp_cnt = j <= 64 ? 4'd5 : 4'd0;
      n_run++;
      if (bus.req_ready !== exp_rr || bus.det_flush !== (j == 65) || bus.fifo_count !== exp_cnt) begin
        n_fail++;
        $display("FAIL timeout_cycle%0d got ready %b flush %b count %0d want %b %b %0d", j, bus.req_ready, bus.det_flush, bus.fifo_count, exp_rr, j == 65, exp_cnt);
      end
      @(posedge clk); #1;
    end
    clr_ok = 1'b0;
    drive(4'b0, 12'b0, 1'b1, 1'b0);
    n_run++;
    if (bus.drop_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL timeout_drop got %0d want 0", bus.drop_cnt);
    end
    repeat (2) @(posedge clk);
    #1 drive(4'b0, 12'b0, 1'b0, 1'b0);
  endtask

  task automatic test_flush_empty;
    do_reset;
    drive(4'b0, 12'b0, 1'b0, 1'b1);
    for (int j = 0; j <= 6; j++) begin
      @(negedge clk); #1;
      n_run++;
      if (bus.det_flush !== (j == 2 || j == 5)) begin
        n_fail++;
        $display("FAIL flush_empty%0d got %b want %b", j, bus.det_flush, j == 2 || j == 5);
      end
      @(posedge clk); #1;
    end
    drive(4'b0, 12'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_priority;
    logic [3:0] exp;
    do_reset;
    drive(4'b0101, {3'd0, 3'd3, 3'd0, 3'd1}, 1'b1, 1'b0);
    @(negedge clk); #1;
`ifdef FLASH_PRIORITY_EN
    exp = 4'b0100;
`else
    exp = 4'b0001;
`endif
    n_run++;
    if (bus.req_ready !== exp) begin
      n_fail++;
      $display("FAIL prio_first got %b want %b", bus.req_ready, exp);
    end
    @(posedge clk); #1 drive(4'b1010, {3'd1, 3'd0, 3'd1, 3'd0}, 1'b1, 1'b0);
    @(negedge clk); #1;
    n_run++;
    if (bus.req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL prio_second got %b want 0010", bus.req_ready);
    end
    @(posedge clk); #1 drive(4'b0001, 12'd1, 1'b1, 1'b0);
    @(negedge clk); #1;
    n_run++;
    if (bus.req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL prio_third got %b want 0001", bus.req_ready);
    end
    @(posedge clk); #1 drive(4'b0, 12'b0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1 drive(4'b0, 12'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_overflow;
    test_drain_flush;
    test_drain_timeout;
    test_flush_empty;
    test_priority;
    @(negedge clk); #1;
    n_run++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover got %0d entries want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/cascade_event_arbiter.md
Name: cascade_event_arbiter

Overview:
Merges anomaly events from NUM_SRC independent requesters into the single one-event-per-cycle stream the cascade detector consumes. Requesters include the rule engine, the ML classifier and the host inject path.
- Round-robin grant; one accept per cycle.
- Small FIFO between arbiter and detector; overflow drops are counted.
- Drain-then-flush sequencer drives the detector's history flush.
- Sits between the alert sources and the cascade detector's rule/event inputs and test_flush.

Parameters:
NUM_SRC, 4, number of requesters (2..8)
DEPTH, 8, FIFO entries (power of 2, >=2)
DRAIN_MAX, 64, max cycles spent in DRAIN before FIFO is force-cleared

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
req_valid  in  NUM_SRC  per-source event request
req_code  in  3*NUM_SRC  source i code at [3i+2:3i]; 1=PRICE_SPIKE 2=VOLUME_SURGE 3=FLASH_CRASH 5=QUOTE_STUFF
req_ready  out  NUM_SRC  one-hot grant, combinational; transfer = req_valid[i]&req_ready[i]
evt_valid  out  1  FIFO head valid (count!=0)
evt_code  out  3  head event code
evt_src  out  SRC_W  head source index, SRC_W = max(1,clog2(NUM_SRC))
evt_ready  in  1  consumer pop; pop = evt_valid&evt_ready
flush_req  in  1  request detector history flush (level, sampled in RUN)
det_flush  out  1  one-cycle registered flush pulse to detector
fifo_count  out  clog2(DEPTH)+1  current occupancy
drop_cnt  out  8  saturating count of events discarded on overflow

Behaviour:
- Reset (async, rst=1): FIFO empty, rr_ptr=0, state RUN, drop_cnt=0, det_flush=0. All outputs read 0.
- Reset mid-operation discards all FIFO contents and any in-progress drain.
- Arbitration in RUN: search req_valid starting at rr_ptr, wrapping. The first valid source i gets req_ready[i]=1, at most one bit set. On grant, rr_ptr <= (i+1) mod NUM_SRC. No valid requester: rr_ptr unchanged.
- Sources never stall: a grant is issued regardless of FIFO space.
- Accepted event, three cases:
  - code==0: consumed, not written.
  - FIFO has space (count<DEPTH, or count==DEPTH with a pop this cycle): written at tail.
  - Otherwise: discarded and drop_cnt increments, saturating at 255.
- Simultaneous push and pop: count unchanged; at full this is not a drop.
- Latency: event accepted at cycle N into an empty FIFO shows on evt_* at N+1. Order is FIFO order.
- evt_code/evt_src are driven from registered storage and hold stable while evt_valid&!evt_ready.
- FSM:
  - RUN: normal operation. flush_req=1 -> DRAIN.
  - DRAIN: req_ready all 0; pops continue.
    - count==0 -> FLUSH.
    - drain cycle counter reaches DRAIN_MAX -> FIFO cleared (entries not counted as drops) -> FLUSH.
  - FLUSH: det_flush=1 for exactly one cycle, req_ready all 0 -> RUN.
- flush_req is ignored in DRAIN and FLUSH. flush_req still high on return to RUN starts a new drain next cycle.
- flush_req with an empty FIFO: RUN -> DRAIN -> FLUSH. det_flush is asserted 2 cycles after flush_req is sampled.
- Pointer arithmetic wraps modulo DEPTH. Count width is sized to hold DEPTH.

Optional Feature:
FLASH_PRIORITY_EN
- Defined: any requester presenting code 3 (FLASH_CRASH) wins over round-robin; the lowest such index wins. A priority grant does not update rr_ptr.
- Undefined: pure round-robin; code 3 gets no preference.

Test Plan:
1. Empty FIFO, src0 valid code 2 one cycle -> req_ready=0001 same cycle; next cycle evt_valid=1, evt_code=2, evt_src=0.
2. All 4 sources held valid with codes 1,2,5,3, evt_ready=1 -> grants 0,1,2,3,0,1... Output codes 1,2,5,3,1,... drop_cnt=0.
3. evt_ready=0, src1 valid 12 cycles code 5 -> fifo_count=8 and drop_cnt=4. Then one cycle with evt_ready=1 and req valid -> count stays 8, drop_cnt stays 4.
4. FIFO holds 3 entries, pulse flush_req, evt_ready=1, src0 valid -> req_ready=0 through DRAIN (3 pops) and FLUSH; det_flush high exactly 1 cycle after count hits 0; grants resume in RUN.
5. FIFO holds 5, evt_ready=0, flush_req -> after 64 DRAIN cycles fifo_count=0 and det_flush pulses; drop_cnt unchanged.
6. FLASH_PRIORITY_EN defined, rr_ptr=0, src0 code 1 and src2 code 3 valid -> src2 granted first, rr_ptr stays 0; src0 granted next. Macro undefined -> src0 first.
